// File: rtl/update_sequencer_pkg.sv
// Shared definitions for the update sequencer and the status engine beside it:
// widths, state encoding, entry status codes and the segment address helper.
package update_sequencer_pkg;

  localparam int KWID    = 104;
  localparam int IDWID   = 8;
  localparam int MASKWID = KWID / 8;
  localparam int DATA    = 2 + IDWID + MASKWID;
  localparam int NSEG    = 8;
  localparam int ADDRWID = 16;
  localparam int TMO     = 4;
  localparam int SEGW    = $clog2(NSEG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_STAT = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Top two bits of every RAM word.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NEW    = 2'b01,
    ST_SHARED = 2'b11
  } status_t;

  // RAM address of one key segment: segment index above the 13 key bits.
  function automatic logic [ADDRWID-1:0] seg_addr(input logic [SEGW-1:0] seg,
                                                  input logic [KWID-1:0] key);
    logic [MASKWID-1:0] kseg;
    kseg = key[seg*MASKWID +: MASKWID];
    return ADDRWID'({seg, kseg});
  endfunction

endpackage

// File: rtl/update_sequencer_if.sv
// RAM and status-engine signals of the update sequencer; master is the
// sequencer side, slave the RAM/status-engine side.
interface update_sequencer_if;
  import update_sequencer_pkg::*;

  // RAM: o_RAM_Rd is a one-cycle strobe, i_RAM_RData is valid the cycle after
  // it; o_RAM_We is a one-cycle strobe with o_RAM_WData valid in that cycle.
  // Engine: o_Status_En stays high until i_Done is seen (or timeout), and
  // i_SETID_MOD is only meaningful in the cycle i_Done=1.
  logic [ADDRWID-1:0] o_RAM_Addr;
  logic               o_RAM_Rd;
  logic [DATA-1:0]    i_RAM_RData;
  logic               o_RAM_We;
  logic [DATA-1:0]    o_RAM_WData;
  logic               o_Status_En;
  logic [IDWID-1:0]   o_SET_ID;
  logic [MASKWID-1:0] o_Mask_Data;
  logic [DATA-1:0]    o_RAM_Data;
  logic [DATA-1:0]    i_SETID_MOD;
  logic               i_Done;

  modport master (
    output o_RAM_Addr, o_RAM_Rd, o_RAM_We, o_RAM_WData,
    output o_Status_En, o_SET_ID, o_Mask_Data, o_RAM_Data,
    input  i_RAM_RData, i_SETID_MOD, i_Done
  );

  modport slave (
    input  o_RAM_Addr, o_RAM_Rd, o_RAM_We, o_RAM_WData,
    input  o_Status_En, o_SET_ID, o_Mask_Data, o_RAM_Data,
    output i_RAM_RData, i_SETID_MOD, i_Done
  );

endinterface

// File: rtl/update_sequencer.sv
// Walks the eight key segments of a rule: read the RAM word, hand it to the
// status engine, write back the modified word, counting shared entries.
module update_sequencer #(
  parameter int KWID    = update_sequencer_pkg::KWID,
  parameter int IDWID   = update_sequencer_pkg::IDWID,
  parameter int MASKWID = update_sequencer_pkg::MASKWID,
  parameter int DATA    = update_sequencer_pkg::DATA,
  parameter int NSEG    = update_sequencer_pkg::NSEG,
  parameter int ADDRWID = update_sequencer_pkg::ADDRWID,
  parameter int TMO     = update_sequencer_pkg::TMO
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_Start,
  input  logic [KWID-1:0]              i_Key,
  input  logic [IDWID-1:0]             i_SET_ID,
  input  logic [MASKWID-1:0]           i_Mask,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_Error,
  output logic [3:0]                   o_Occupied,
  output update_sequencer_pkg::state_t o_State,
  update_sequencer_if.master           bus
);
  import update_sequencer_pkg::state_t, update_sequencer_pkg::status_t;
  import update_sequencer_pkg::S_IDLE, update_sequencer_pkg::S_RD;
  import update_sequencer_pkg::S_CAP, update_sequencer_pkg::S_STAT;
  import update_sequencer_pkg::S_WR, update_sequencer_pkg::S_DONE;
  import update_sequencer_pkg::ST_SHARED;

  localparam int SEGW = $clog2(NSEG);
  localparam int TMOW = $clog2(TMO + 1);
  localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO - 1);

  state_t             state, nstate;
  logic [KWID-1:0]    key_q;
  logic [IDWID-1:0]   id_q;
  logic [MASKWID-1:0] mask_q;
  logic [SEGW-1:0]    seg_q;
  logic [TMOW-1:0]    tmo_q;
  logic [DATA-1:0]    hold_q;
  logic [DATA-1:0]    mod_q;
  logic [3:0]         occ_q;
  logic               err_q;
  logic [MASKWID-1:0] key_seg;
  logic               tmo_hit;

  assign key_seg = key_q[seg_q*MASKWID +: MASKWID];
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      key_q  <= '0;
      id_q   <= '0;
      mask_q <= '0;
      seg_q  <= '0;
      tmo_q  <= '0;
      hold_q <= '0;
      mod_q  <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            key_q  <= i_Key;
            id_q   <= i_SET_ID;
            mask_q <= i_Mask;
            seg_q  <= '0;
            tmo_q  <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
          end
        end
        S_CAP: begin
          hold_q <= bus.i_RAM_RData;
          tmo_q  <= '0;
        end
        S_STAT: begin
          // i_Done wins over a timeout landing in the same cycle.
          if (bus.i_Done) begin
            mod_q <= bus.i_SETID_MOD;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WR: begin
          if (status_t'(mod_q[DATA-1 -: 2]) == ST_SHARED) begin
            occ_q <= occ_q + 4'd1;
          end
          seg_q <= seg_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate          = state;
    o_Busy          = 1'b1;
    o_Done          = 1'b0;
    bus.o_RAM_Rd    = 1'b0;
    bus.o_RAM_We    = 1'b0;
    bus.o_Status_En = 1'b0;
    bus.o_SET_ID    = '0;
    bus.o_Mask_Data = '0;
    bus.o_RAM_Addr  = ADDRWID'({seg_q, key_seg});
    case (state)
      S_IDLE: begin
        o_Busy         = 1'b0;
        bus.o_RAM_Addr = '0;
        if (i_Start) nstate = S_RD;
      end
      S_RD: begin
        bus.o_RAM_Rd = 1'b1;
        nstate       = S_CAP;
      end
      S_CAP: begin
        nstate = S_STAT;
      end
      S_STAT: begin
        bus.o_Status_En = 1'b1;
        bus.o_SET_ID    = id_q;
        bus.o_Mask_Data = mask_q;
        if (bus.i_Done)   nstate = S_WR;
        else if (tmo_hit) nstate = S_DONE;
      end
      S_WR: begin
        bus.o_RAM_We = 1'b1;
        nstate       = (seg_q == SEG_LAST) ? S_DONE : S_RD;
      end
      S_DONE: begin
        o_Done         = 1'b1;
        bus.o_RAM_Addr = '0;
        nstate         = S_IDLE;
      end
      default: begin
        bus.o_RAM_Addr = '0;
        nstate         = S_IDLE;
      end
    endcase
  end

  assign bus.o_RAM_WData = mod_q;
  assign bus.o_RAM_Data  = hold_q;
  assign o_Occupied      = occ_q;
  assign o_Error         = err_q;
  assign o_State         = state;

  rd_we_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.o_RAM_Rd && bus.o_RAM_We));

endmodule

// File: tb/tb_update_sequencer.sv
// Randomized bench for update_sequencer: RAM and status-engine models, a
// segment-level reference model feeding an expected-write queue, and a report.
module tb_update_sequencer;
  import update_sequencer_pkg::*;

  localparam int W = ADDRWID + DATA;

  logic               clk;
  logic               rst;
  logic               i_Start;
  logic [KWID-1:0]    i_Key;
  logic [IDWID-1:0]   i_SET_ID;
  logic [MASKWID-1:0] i_Mask;
  logic               o_Busy;
  logic               o_Done;
  logic               o_Error;
  logic [3:0]         o_Occupied;
  state_t             o_State;

  update_sequencer_if bus();

  update_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_Start    (i_Start),
    .i_Key      (i_Key),
    .i_SET_ID   (i_SET_ID),
    .i_Mask     (i_Mask),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Error    (o_Error),
    .o_Occupied (o_Occupied),
    .o_State    (o_State),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]       exp_q[$];
  logic [DATA-1:0]    ram [0:(1<<ADDRWID)-1];
  int                 n_checks;
  int                 n_errors;
  int                 exp_occ;
  logic               exp_err;
  int                 exp_done;
  int                 hold_seg;
  logic [IDWID-1:0]   cur_id;
  logic [MASKWID-1:0] cur_mask;
  int                 en_cnt;
  logic               rd_pend;
  logic [ADDRWID-1:0] rd_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KWID-1:0] rand_key();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[KWID-1:0];
  endfunction

  // Status engine rule used by the bench: empty entries become new entries
  // owned by the requesting set; occupied entries come back unchanged.
  function automatic logic [DATA-1:0] engine_mod(input logic [DATA-1:0] w,
                                                 input logic [IDWID-1:0] id,
                                                 input logic [MASKWID-1:0] m);
    if (w[DATA-1 -: 2] == 2'b00) return {2'b01, id, m};
    return w;
  endfunction

  // ---------------- RAM, status engine, write monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      en_cnt          = 0;
      rd_pend         = 1'b0;
      bus.i_Done      = 1'b0;
      bus.i_SETID_MOD = '0;
    end else begin
      if (rd_pend) bus.i_RAM_RData = ram[rd_addr];
      else         bus.i_RAM_RData = DATA'($urandom);
      rd_pend = bus.o_RAM_Rd;
      rd_addr = bus.o_RAM_Addr;
      if (bus.o_RAM_We) begin
        if (exp_q.size() == 0) check("write_extra", 64'(exp_q.size()), 64'd1);
        else check("write", 64'({bus.o_RAM_Addr, bus.o_RAM_WData}), 64'(exp_q.pop_front()));
        ram[bus.o_RAM_Addr] = bus.o_RAM_WData;
      end
      if (bus.o_Status_En) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("stat_set_id", 64'(bus.o_SET_ID), 64'(cur_id));
          check("stat_mask", 64'(bus.o_Mask_Data), 64'(cur_mask));
        end
        if (en_cnt == 2 && int'(bus.o_RAM_Addr[ADDRWID-1 -: SEGW]) != hold_seg) begin
          bus.i_Done      = 1'b1;
          bus.i_SETID_MOD = engine_mod(bus.o_RAM_Data, bus.o_SET_ID, bus.o_Mask_Data);
        end else begin
          bus.i_Done = 1'b0;
        end
      end else begin
        en_cnt     = 0;
        bus.i_Done = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Segments before `hold` (engine silent there) and before `limit` get
  // written; a silent segment ends the update with an error.
  task automatic build_expect(input logic [KWID-1:0] key, input int hold, input int limit);
    logic [ADDRWID-1:0] a;
    logic [DATA-1:0]    w;
    logic [2:0]         s3;
    exp_q.delete();
    exp_occ = 0;
    exp_err = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (s == hold) begin
        exp_err = 1'b1;
        break;
      end
      if (s >= limit) break;
      s3 = 3'(s);
      a  = {s3, key[s*MASKWID +: MASKWID]};
      w  = engine_mod(ram[a], cur_id, cur_mask);
      exp_q.push_back({a, w});
      if (w[DATA-1 -: 2] == 2'b11) exp_occ++;
    end
    // Five cycles per finished segment; a silent one costs RD, CAP, TMO STAT.
    exp_done = (hold < NSEG) ? 5 * hold + 2 + TMO + 1 : 5 * NSEG + 1;
  endtask

  task automatic clear_ram();
    for (int a = 0; a < (1 << ADDRWID); a++) ram[a] = '0;
  endtask

  task automatic preload_key(input logic [KWID-1:0] key);
    logic [2:0] s3;
    int         r;
    for (int s = 0; s < NSEG; s++) begin
      s3 = 3'(s);
      r  = $urandom_range(0, 2);
      ram[{s3, key[s*MASKWID +: MASKWID]}] =
        (r == 0) ? '0 : {(r == 1) ? 2'b01 : 2'b11, 21'($urandom)};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_update(input logic [KWID-1:0] key, input logic [IDWID-1:0] id,
                              input logic [MASKWID-1:0] mask);
    @(negedge clk);
    i_Start  = 1'b1;
    i_Key    = key;
    i_SET_ID = id;
    i_Mask   = mask;
    @(negedge clk);
    // Inputs change right after acceptance; the latched copies must be used.
    i_Start  = 1'b0;
    i_Key    = rand_key();
    i_SET_ID = IDWID'($urandom);
    i_Mask   = MASKWID'($urandom);
  endtask

  task automatic run_update(input logic [KWID-1:0] key, input logic [IDWID-1:0] id,
                            input logic [MASKWID-1:0] mask, input int hold,
                            input int pulse_cyc, input string tag);
    int cyc;
    int done_cyc;
    cur_id   = id;
    cur_mask = mask;
    hold_seg = hold;
    build_expect(key, hold, NSEG);
    start_update(key, id, mask);
    check({tag, "_busy_c1"}, 64'(o_Busy), 64'd1);
    check({tag, "_occ_clr"}, 64'(o_Occupied), 64'd0);
    check({tag, "_err_clr"}, 64'(o_Error), 64'd0);
    cyc      = 1;
    done_cyc = 0;
    while (cyc < 200 && done_cyc == 0) begin
      if (o_Done) begin
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
        i_Start = (cyc == pulse_cyc);
        if (cyc == pulse_cyc) begin
          i_Key    = rand_key();
          i_SET_ID = IDWID'($urandom);
          i_Mask   = MASKWID'($urandom);
        end
      end
    end
    i_Start = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, "_occupied"}, 64'(o_Occupied), 64'(exp_occ));
    check({tag, "_error"}, 64'(o_Error), 64'(exp_err));
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 64'(o_Done), 64'd0);
    check({tag, "_idle_busy"}, 64'(o_Busy), 64'd0);
    check({tag, "_error_hold"}, 64'(o_Error), 64'(exp_err));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Reset lands in the write cycle of segment 4: segments 0-3 are written,
  // segment 4 must not be, and nothing resumes afterwards.
  task automatic run_reset_mid(input logic [KWID-1:0] key);
    cur_id   = IDWID'($urandom);
    cur_mask = MASKWID'($urandom);
    hold_seg = NSEG;
    build_expect(key, NSEG, 4);
    start_update(key, cur_id, cur_mask);
    repeat (23) @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_pre_we", 64'(bus.o_RAM_We), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_we_low", 64'(bus.o_RAM_We), 64'd0);
    check("rst_ctrl", 64'({o_Busy, o_Done, o_Error, o_Occupied, bus.o_RAM_Rd,
                           bus.o_Status_En}), 64'd0);
    check("rst_addr_wdata", 64'({bus.o_RAM_Addr, bus.o_RAM_WData}), 64'd0);
    check("rst_engine_bus", 64'({bus.o_SET_ID, bus.o_Mask_Data, bus.o_RAM_Data}), 64'd0);
    check("rst_state", 64'(o_State), 64'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_resume", 64'(o_Busy), 64'd0);
    check("rst_writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [KWID-1:0]    k;
    logic [ADDRWID-1:0] a3;
    int                 h;
    int                 p;
    n_checks        = 0;
    n_errors        = 0;
    hold_seg        = NSEG;
    cur_id          = '0;
    cur_mask        = '0;
    en_cnt          = 0;
    rd_pend         = 1'b0;
    rd_addr         = '0;
    rst             = 1'b1;
    i_Start         = 1'b0;
    i_Key           = '0;
    i_SET_ID        = '0;
    i_Mask          = '0;
    bus.i_RAM_RData = '0;
    bus.i_SETID_MOD = '0;
    bus.i_Done      = 1'b0;
    clear_ram();
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({o_Busy, o_Done, o_Error, o_Occupied, bus.o_RAM_Rd,
                             bus.o_RAM_We, bus.o_Status_En}), 64'd0);
    check("reset_state", 64'(o_State), 64'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(o_Busy), 64'd0);

    // Empty RAM, key 0: eight new entries, nothing shared.
    run_update('0, 8'h5A, 13'h1FFF, NSEG, 0, "empty");
    check("empty_word_seg7", 64'(ram[16'hE000]), 64'h2B5FFF);

    // One shared entry on segment 3 passes through and is counted.
    clear_ram();
    k  = rand_key();
    a3 = seg_addr(3'd3, k);
    ram[a3] = 23'h6ABCDE;
    run_update(k, 8'($urandom), 13'($urandom), NSEG, 0, "shared3");
    check("shared3_word", 64'(ram[a3]), 64'h6ABCDE);

    // Engine silent on segment 2: timeout, error, segments 2-7 untouched.
    clear_ram();
    k = rand_key();
    preload_key(k);
    run_update(k, 8'($urandom), 13'($urandom), 2, 0, "timeout2");

    // Second start mid-update is ignored.
    k = rand_key();
    preload_key(k);
    run_update(k, 8'($urandom), 13'($urandom), NSEG, 10, "restart10");

    // Reset during segment 4 write, then a clean full update.
    k = rand_key();
    preload_key(k);
    run_reset_mid(k);
    k = rand_key();
    preload_key(k);
    run_update(k, 8'($urandom), 13'($urandom), NSEG, 0, "after_rst");

    for (int t = 0; t < 8; t++) begin
      k = rand_key();
      preload_key(k);
      h = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NSEG - 1) : NSEG;
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : 0;
      run_update(k, 8'($urandom), 13'($urandom), h, p, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/update_sequencer.md
UPDATE_SEQUENCER -- requirements
Module: update_sequencer

Interface
REQ-001 SHALL have parameters: KWID 104, key width; IDWID 8, set-ID width; MASKWID KWID/8 = 13, segment/mask width; DATA 2+IDWID+MASKWID = 23, RAM word width; NSEG 8, segment count; ADDRWID 16, RAM address width; TMO 4, status-engine timeout in cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: i_Start  in  1  begin update; i_Key  in  KWID  rule key; i_SET_ID  in  IDWID  set ID; i_Mask  in  MASKWID  mask.
REQ-004 SHALL have RAM ports: o_RAM_Addr  out  ADDRWID  address; o_RAM_Rd  out  1  read strobe; i_RAM_RData  in  DATA  read data, valid the cycle after o_RAM_Rd; o_RAM_We  out  1  write strobe; o_RAM_WData  out  DATA  write data.
REQ-005 SHALL have status-engine ports: o_Status_En  out  1; o_SET_ID  out  IDWID; o_Mask_Data  out  MASKWID; o_RAM_Data  out  DATA; i_SETID_MOD  in  DATA  modified word; i_Done  in  1  engine done.
REQ-006 SHALL have status ports: o_Busy  out  1; o_Done  out  1  one-cycle completion pulse; o_Error  out  1  timeout flag; o_Occupied  out  4  count of occupied segments (0-8).

Function
REQ-007 SHALL latch i_Key, i_SET_ID, i_Mask on the edge where i_Start=1 in IDLE; i_Start outside IDLE SHALL be ignored.
REQ-008 SHALL implement states IDLE, RD, CAP, STAT, WR, DONE; IDLE->RD on accepted start; RD->CAP; CAP->STAT; STAT->WR on i_Done=1; WR->RD if seg<NSEG-1, else WR->DONE; DONE->IDLE.
REQ-009 Segment s (0..7) SHALL use key bits [13s+12:13s]; o_RAM_Addr = {s[2:0], key segment} in RD, CAP, STAT and WR.
REQ-010 RD SHALL assert o_RAM_Rd for one cycle; CAP SHALL register i_RAM_RData into a hold register driven on o_RAM_Data.
REQ-011 STAT SHALL hold o_Status_En=1 with o_SET_ID, o_Mask_Data = latched values; o_Status_En SHALL be 0 in all other states, so the engine re-enters idle between segments.
REQ-012 On the cycle i_Done=1 in STAT, i_SETID_MOD SHALL be registered; WR SHALL assert o_RAM_We for exactly one cycle with o_RAM_WData = that register.
REQ-013 With a compliant engine (Done on 2nd enabled cycle), each segment SHALL take 5 cycles (RD, CAP, STAT x2, WR); accepted start to o_Done pulse SHALL be 41 cycles.
REQ-014 o_Occupied SHALL clear on accepted start and increment in WR when o_RAM_WData[DATA-1:DATA-2] = 2'b11.
REQ-015 If i_Done is not seen within TMO cycles in STAT, the block SHALL skip WR, set o_Error=1 and go to DONE; remaining segments SHALL NOT be touched.
REQ-016 o_Error SHALL hold until the next accepted start, which clears it.
REQ-017 o_Busy SHALL be 1 in every state except IDLE; o_Done SHALL be 1 only in DONE.
REQ-018 o_RAM_Rd and o_RAM_We SHALL never be high in the same cycle.

Reset
REQ-019 rst=1 SHALL asynchronously force IDLE and zero all outputs, registers, segment index and timeout counter, with no write strobe; an update interrupted by rst SHALL NOT resume.

Structure
REQ-020 KWID, IDWID, MASKWID, DATA, NSEG, ADDRWID, TMO, state encoding and status codes (00 empty, 01 new, 11 shared) SHALL reside in a shared package common with the status engine.
REQ-021 SHALL be a single module with no sub-module; the status engine is instantiated beside it at the next level up.

Verification
REQ-022 Empty RAM, key 0, SET_ID 8'h5A, mask 13'h1FFF -> 8 writes to addresses 16'h0000, 16'h2000 ... 16'hE000, data 23'h2B5FFF, o_Occupied 0, o_Done at cycle 41.
REQ-023 Segment 3 preloaded 23'h6ABCDE, other segments empty -> segment-3 write data 23'h6ABCDE, o_Occupied 1, o_Error 0.
REQ-024 Engine model withholding i_Done on segment 2 -> no write for segments 2-7, o_Error 1 after 4 STAT cycles, o_Done pulse, o_Occupied equals count from segments 0-1.
REQ-025 i_Start pulsed again at cycle 10 of an update -> ignored; latched key unchanged; exactly 8 writes.
REQ-026 rst asserted during segment 4 WR -> o_RAM_We low same cycle, all outputs 0, IDLE; new i_Start runs full 41-cycle update.
